// File: rtl/sap_pkg.sv
// Shared SAP datapath encodings: register-bank operations and the bank's shift sequencer states.
package sap_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_CLR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_ROR  = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic logic is_shift_op(input logic [2:0] o);
        return (o == OP_SHL) || (o == OP_SHR) || (o == OP_ROR);
    endfunction

endpackage

// File: rtl/sap_regbank_step.sv
// Single-step arithmetic/shift kernel: one value in, one result plus carry/zero flags out.
module sap_regbank_step
    import sap_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             zero_o
);

    always_comb begin
        result_o = value_i;
        carry_o  = 1'b0;
        case (op_i)
            OP_INC:  {carry_o, result_o} = {1'b0, value_i} + (WIDTH+1)'(1);
            // Borrow propagates into the extra top bit only when value_i is zero.
            OP_DEC:  {carry_o, result_o} = {1'b0, value_i} - (WIDTH+1)'(1);
            OP_CLR:  result_o = '0;
            OP_SHL: begin
                result_o = {value_i[WIDTH-2:0], 1'b0};
                carry_o  = value_i[WIDTH-1];
            end
            OP_SHR: begin
                result_o = {1'b0, value_i[WIDTH-1:1]};
                carry_o  = value_i[0];
            end
            OP_ROR: begin
                result_o = {value_i[0], value_i[WIDTH-1:1]};
                carry_o  = value_i[0];
            end
            default: ;
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/sap_regbank.sv
// General register bank with load/inc/dec/clear and multi-cycle shifts, gated by clken.
module sap_regbank
    import sap_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SW    = $clog2(WIDTH) + 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             clken,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SW-1:0]    shamt,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             busy,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    state_e           state_q, state_d;
    logic [SW-1:0]    rem_q, rem_d;
    logic [AW-1:0]    lat_addr_q, lat_addr_d;
    logic [2:0]       lat_op_q, lat_op_d;
    logic             busy_q, busy_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic [AW-1:0]    sel_addr;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] step_result;
    logic             step_carry;
    logic             step_zero;
    logic [SW-1:0]    n_shift;

    // One step unit serves both a fresh op and the continuing shift.
    assign sel_addr = (state_q == ST_SHIFT) ? lat_addr_q : waddr;
    assign sel_op   = (state_q == ST_SHIFT) ? lat_op_q   : op;
    assign n_shift  = (shamt > SW'(WIDTH)) ? SW'(WIDTH) : shamt;

    sap_regbank_step #(.WIDTH(WIDTH)) u_step (
        .value_i  (regs_q[sel_addr]),
        .op_i     (sel_op),
        .result_o (step_result),
        .carry_o  (step_carry),
        .zero_o   (step_zero)
    );

    always_comb begin
        regs_d     = regs_q;
        state_d    = state_q;
        rem_d      = rem_q;
        lat_addr_d = lat_addr_q;
        lat_op_d   = lat_op_q;
        busy_d     = busy_q;
        carry_d    = carry_q;
        zero_d     = zero_q;

        if (clken) begin
            if (state_q == ST_SHIFT) begin
                regs_d[lat_addr_q] = step_result;
                carry_d            = step_carry;
                zero_d             = step_zero;
                rem_d              = rem_q - SW'(1);
                if (rem_q == SW'(1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end else if (op == OP_LOAD) begin
                regs_d[waddr] = data_in;
            end else if (op == OP_INC || op == OP_DEC || op == OP_CLR) begin
                regs_d[waddr] = step_result;
                carry_d       = step_carry;
                zero_d        = step_zero;
            end else if (is_shift_op(op)) begin
                if (n_shift == '0) begin
                    carry_d = 1'b0;
                    zero_d  = (regs_q[waddr] == '0);
                end else begin
                    regs_d[waddr] = step_result;
                    carry_d       = step_carry;
                    zero_d        = step_zero;
                    if (n_shift > SW'(1)) begin
                        lat_addr_d = waddr;
                        lat_op_d   = op;
                        rem_d      = n_shift - SW'(1);
                        state_d    = ST_SHIFT;
                        busy_d     = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            lat_addr_q <= '0;
            lat_op_q   <= OP_HOLD;
            busy_q     <= 1'b0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            regs_q     <= regs_d;
            state_q    <= state_d;
            rem_q      <= rem_d;
            lat_addr_q <= lat_addr_d;
            lat_op_q   <= lat_op_d;
            busy_q     <= busy_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];
    assign busy    = busy_q;
    assign carry   = carry_q;
    assign zero    = zero_q;

endmodule

// File: tb/tb_sap_regbank.sv
// Directed bench for sap_regbank: vector table for single-cycle ops, hand sequences for shifts/stall/reset.
module tb_sap_regbank;

    logic       sysclk = 1'b0;
    logic       reset_n;
    logic       clken;
    logic [2:0] op;
    logic [1:0] waddr;
    logic [7:0] data_in;
    logic [3:0] shamt;
    logic [1:0] raddr_a, raddr_b;
    logic [7:0] rdata_a, rdata_b;
    logic       busy, carry, zero;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, INC = 3'b010, DEC = 3'b011,
                           CLR  = 3'b100, SHL  = 3'b101, SHR = 3'b110, ROR = 3'b111;

    sap_regbank #(.WIDTH(8), .DEPTH(4)) dut (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .clken   (clken),
        .op      (op),
        .waddr   (waddr),
        .data_in (data_in),
        .shamt   (shamt),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .busy    (busy),
        .carry   (carry),
        .zero    (zero)
    );

    always #5 sysclk = ~sysclk;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] waddr;
        logic [7:0] din;
        logic [3:0] shamt;
        logic       ck;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ec;
        logic       ez;
        logic       ebusy;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // {rdata_a, carry, zero, busy}
    function automatic logic [31:0] st();
        return {21'd0, rdata_a, carry, zero, busy};
    endfunction

    task automatic edge1();
        @(posedge sysclk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [1:0] a, input logic [7:0] d,
                         input logic [3:0] s);
        op = o; waddr = a; data_in = d; shamt = s;
    endtask

    initial begin
        reset_n = 1'b0; clken = 1'b1;
        op = HOLD; waddr = '0; data_in = '0; shamt = '0;
        raddr_a = 2'd0; raddr_b = 2'd0;

        //            op    wa     din    sh   ck  ra  rb   ea     eb     c  z  b
        vecs[0]  = '{LOAD, 2'd2, 8'hA5, 4'd0, 1, 2'd2, 2'd0, 8'hA5, 8'h00, 0, 1, 0};
        vecs[1]  = '{HOLD, 2'd0, 8'h00, 4'd0, 1, 2'd1, 2'd3, 8'h00, 8'h00, 0, 1, 0};
        vecs[2]  = '{LOAD, 2'd1, 8'hFF, 4'd0, 1, 2'd1, 2'd2, 8'hFF, 8'hA5, 0, 1, 0};
        vecs[3]  = '{INC,  2'd1, 8'h00, 4'd0, 1, 2'd1, 2'd2, 8'h00, 8'hA5, 1, 1, 0};
        vecs[4]  = '{INC,  2'd1, 8'h00, 4'd0, 1, 2'd1, 2'd2, 8'h01, 8'hA5, 0, 0, 0};
        vecs[5]  = '{CLR,  2'd3, 8'h00, 4'd0, 1, 2'd3, 2'd1, 8'h00, 8'h01, 0, 1, 0};
        vecs[6]  = '{DEC,  2'd3, 8'h00, 4'd0, 1, 2'd3, 2'd1, 8'hFF, 8'h01, 1, 0, 0};
        vecs[7]  = '{INC,  2'd3, 8'h00, 4'd0, 0, 2'd3, 2'd3, 8'hFF, 8'hFF, 1, 0, 0};
        vecs[8]  = '{SHL,  2'd3, 8'h00, 4'd0, 1, 2'd3, 2'd3, 8'hFF, 8'hFF, 0, 0, 0};
        vecs[9]  = '{ROR,  2'd2, 8'h00, 4'd1, 1, 2'd2, 2'd2, 8'hD2, 8'hD2, 1, 0, 0};
        vecs[10] = '{DEC,  2'd0, 8'h00, 4'd0, 1, 2'd0, 2'd2, 8'hFF, 8'hD2, 1, 0, 0};
        vecs[11] = '{SHR,  2'd0, 8'h00, 4'd1, 1, 2'd0, 2'd1, 8'h7F, 8'h01, 1, 0, 0};
        vecs[12] = '{LOAD, 2'd0, 8'h00, 4'd0, 1, 2'd0, 2'd0, 8'h00, 8'h00, 1, 0, 0};
        vecs[13] = '{SHL,  2'd0, 8'h00, 4'd0, 1, 2'd0, 2'd0, 8'h00, 8'h00, 0, 1, 0};
        vecs[14] = '{DEC,  2'd0, 8'h00, 4'd0, 1, 2'd0, 2'd3, 8'hFF, 8'hFF, 1, 0, 0};

        repeat (2) @(posedge sysclk);
        #1;
        chk("reset_state", st(), {21'd0, 8'h00, 1'b0, 1'b1, 1'b0});
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].op, vecs[i].waddr, vecs[i].din, vecs[i].shamt);
            clken = vecs[i].ck; raddr_a = vecs[i].ra; raddr_b = vecs[i].rb;
            edge1();
            chk($sformatf("vec[%0d]", i), {13'd0, rdata_a, rdata_b, carry, zero, busy},
                {13'd0, vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ez, vecs[i].ebusy});
        end
        drive(HOLD, 2'd0, 8'h00, 4'd0); clken = 1'b1;

        // Asynchronous reset pulse mid-run clears every register and the flags.
        reset_n = 1'b0;
        for (int r = 0; r < 4; r++) begin
            raddr_a = 2'(r);
            #1;
            chk($sformatf("rst_reg%0d", r), {24'd0, rdata_a}, 32'h0);
        end
        chk("rst_flags", st(), {21'd0, 8'h00, 1'b0, 1'b1, 1'b0});
        reset_n = 1'b1;

        // SHL by 3 on r0, with a LOAD attempted while busy.
        raddr_a = 2'd0;
        drive(LOAD, 2'd0, 8'hB1, 4'd0); edge1();
        chk("shl_load", st(), {21'd0, 8'hB1, 1'b0, 1'b1, 1'b0});
        drive(SHL, 2'd0, 8'h00, 4'd3); edge1();
        chk("shl_step1", st(), {21'd0, 8'h62, 1'b1, 1'b0, 1'b1});
        drive(LOAD, 2'd0, 8'h55, 4'd0); edge1();
        chk("shl_step2", st(), {21'd0, 8'hC4, 1'b0, 1'b0, 1'b1});
        edge1();
        chk("shl_step3", st(), {21'd0, 8'h88, 1'b1, 1'b0, 1'b0});
        drive(HOLD, 2'd0, 8'h00, 4'd0); edge1();
        chk("shl_after", st(), {21'd0, 8'h88, 1'b1, 1'b0, 1'b0});

        // ROR by 2 on r1 with a three-cycle clken stall after the first step.
        raddr_a = 2'd1;
        drive(LOAD, 2'd1, 8'h01, 4'd0); edge1();
        drive(ROR, 2'd1, 8'h00, 4'd2); edge1();
        chk("ror_step1", st(), {21'd0, 8'h80, 1'b1, 1'b0, 1'b1});
        drive(HOLD, 2'd0, 8'h00, 4'd0); clken = 1'b0;
        for (int k = 0; k < 3; k++) begin
            edge1();
            chk($sformatf("ror_stall%0d", k), st(), {21'd0, 8'h80, 1'b1, 1'b0, 1'b1});
        end
        clken = 1'b1; edge1();
        chk("ror_step2", st(), {21'd0, 8'h40, 1'b0, 1'b0, 1'b0});

        // SHR by 8 on r2, abandoned by reset after the third step.
        raddr_a = 2'd2;
        drive(LOAD, 2'd2, 8'hFF, 4'd0); edge1();
        drive(SHR, 2'd2, 8'h00, 4'd8); edge1();
        chk("shr_step1", st(), {21'd0, 8'h7F, 1'b1, 1'b0, 1'b1});
        drive(HOLD, 2'd0, 8'h00, 4'd0);
        edge1(); edge1();
        chk("shr_step3", st(), {21'd0, 8'h1F, 1'b1, 1'b0, 1'b1});
        reset_n = 1'b0; #1;
        chk("shr_reset", st(), {21'd0, 8'h00, 1'b0, 1'b1, 1'b0});
        #2 reset_n = 1'b1;
        drive(LOAD, 2'd2, 8'h3C, 4'd0); edge1();
        chk("post_reset_load", st(), {21'd0, 8'h3C, 1'b0, 1'b1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
